// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// to instruction memory over req/ack, and feeds decode through a registered
// output slot backed by a one-entry skid buffer.
module stage_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de_stall,
  input  logic        de_setpc,
  input  logic [29:0] de_newpc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic        de_valid,
  output logic        de_exc,
  output logic [31:0] de_insn,
  output logic [29:0] de_pc
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_KILL = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [29:0] req_pc_r;
  logic [29:0] req_pc_nxt_s;
  logic [29:0] next_pc_r;
  logic [29:0] next_pc_nxt_s;

  logic        skid_valid_r;
  logic [31:0] skid_insn_r;
  logic [29:0] skid_pc_r;
  logic        skid_exc_r;
  logic        skid_valid_nxt_s;
  logic [31:0] skid_insn_nxt_s;
  logic [29:0] skid_pc_nxt_s;
  logic        skid_exc_nxt_s;

  logic        de_valid_r;
  logic [31:0] de_insn_r;
  logic [29:0] de_pc_r;
  logic        de_exc_r;
  logic        de_valid_nxt_s;
  logic [31:0] de_insn_nxt_s;
  logic [29:0] de_pc_nxt_s;
  logic        de_exc_nxt_s;

  logic        imem_req_s;
  logic        ack_s;
  logic        accept_s;
  logic        slot_free_s;
  logic [31:0] resp_insn_s;

  // A request is only outstanding while fetching and with room for the reply;
  // gating with reset_n drops it the instant reset asserts.
  assign imem_req_s  = ((state_r == ST_RUN) || (state_r == ST_KILL)) && !skid_valid_r && reset_n;
  // Acks arriving with no request raised (e.g. stale after reset) are ignored.
  assign ack_s       = imem_ack && imem_req_s;
  // Only a RUN-state ack without a same-cycle redirect produces an instruction.
  assign accept_s    = (state_r == ST_RUN) && ack_s && !de_setpc;
  assign slot_free_s = !de_valid_r || !de_stall;
  // Faulting slots carry a zero word so decode never sees garbage.
  assign resp_insn_s = imem_fault ? 32'h0000_0000 : imem_rdata;

  assign imem_req  = imem_req_s;
  assign imem_addr = req_pc_r;
  assign de_valid  = de_valid_r;
  assign de_exc    = de_exc_r;
  assign de_insn   = de_insn_r;
  assign de_pc     = de_pc_r;

  // Next-state logic for the fetch FSM and the two PC registers.
  always_comb begin
    state_nxt_s   = state_r;
    req_pc_nxt_s  = req_pc_r;
    next_pc_nxt_s = next_pc_r;
    if (de_setpc) begin
      if (imem_req_s && !ack_s) begin
        // Cannot retract a live request: park the target until its ack.
        next_pc_nxt_s = de_newpc;
        state_nxt_s   = ST_KILL;
      end else begin
        req_pc_nxt_s = de_newpc;
        state_nxt_s  = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ack_s) begin
            if (imem_fault) begin
              state_nxt_s = ST_HALT;
            end else begin
              req_pc_nxt_s = req_pc_r + 30'd1;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_KILL: begin
          if (ack_s) begin
            req_pc_nxt_s = next_pc_r;
            state_nxt_s  = ST_RUN;
          end else begin
            state_nxt_s = ST_KILL;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_RUN;
      req_pc_r  <= RESET_PC;
      next_pc_r <= 30'h0;
    end else begin
      state_r   <= state_nxt_s;
      req_pc_r  <= req_pc_nxt_s;
      next_pc_r <= next_pc_nxt_s;
    end
  end

  // Output slot and skid buffer update, in redirect > stall > skid > new data order.
  always_comb begin
    skid_valid_nxt_s = skid_valid_r;
    skid_insn_nxt_s  = skid_insn_r;
    skid_pc_nxt_s    = skid_pc_r;
    skid_exc_nxt_s   = skid_exc_r;
    de_valid_nxt_s   = de_valid_r;
    de_insn_nxt_s    = de_insn_r;
    de_pc_nxt_s      = de_pc_r;
    de_exc_nxt_s     = de_exc_r;
    if (de_setpc) begin
      de_valid_nxt_s   = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!slot_free_s) begin
      // Output held; a reply that lands now is parked in the skid.
      if (accept_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_insn_nxt_s  = resp_insn_s;
        skid_pc_nxt_s    = req_pc_r;
        skid_exc_nxt_s   = imem_fault;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end else if (skid_valid_r) begin
      de_valid_nxt_s   = 1'b1;
      de_insn_nxt_s    = skid_insn_r;
      de_pc_nxt_s      = skid_pc_r;
      de_exc_nxt_s     = skid_exc_r;
      skid_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      de_valid_nxt_s = 1'b1;
      de_insn_nxt_s  = resp_insn_s;
      de_pc_nxt_s    = req_pc_r;
      de_exc_nxt_s   = imem_fault;
    end else begin
      de_valid_nxt_s = 1'b0;
    end
  end

  // Skid buffer and decode-facing output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_r <= 1'b0;
      skid_insn_r  <= 32'h0000_0000;
      skid_pc_r    <= 30'h0;
      skid_exc_r   <= 1'b0;
      de_valid_r   <= 1'b0;
      de_insn_r    <= 32'h0000_0000;
      de_pc_r      <= 30'h0;
      de_exc_r     <= 1'b0;
    end else begin
      skid_valid_r <= skid_valid_nxt_s;
      skid_insn_r  <= skid_insn_nxt_s;
      skid_pc_r    <= skid_pc_nxt_s;
      skid_exc_r   <= skid_exc_nxt_s;
      de_valid_r   <= de_valid_nxt_s;
      de_insn_r    <= de_insn_nxt_s;
      de_pc_r      <= de_pc_nxt_s;
      de_exc_r     <= de_exc_nxt_s;
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: a memory model with programmable wait
// states answers requests; directed stimulus pushes expected memory addresses
// and expected decode deliveries into queues, and a monitor pops/compares.
module tb_stage_fetch;

  logic        clk;
  logic        reset_n;
  logic        de_stall;
  logic        de_setpc;
  logic [29:0] de_newpc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_fault;
  logic        de_valid;
  logic        de_exc;
  logic [31:0] de_insn;
  logic [29:0] de_pc;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        exc;
  } slot_t;

  slot_t       exp_de_q[$];
  logic [29:0] exp_addr_q[$];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic        fault_en  = 1'b0;
  logic [29:0] fault_addr = 30'd2;

  stage_fetch #(.RESET_PC(30'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .de_stall   (de_stall),
    .de_setpc   (de_setpc),
    .de_newpc   (de_newpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_fault (imem_fault),
    .de_valid   (de_valid),
    .de_exc     (de_exc),
    .de_insn    (de_insn),
    .de_pc      (de_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data pattern stored in the instruction memory at each word address.
  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {2'b01, a} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks once the request has waited mem_delay cycles.
  assign imem_ack   = imem_req && (wait_cnt >= mem_delay);
  assign imem_rdata = insn_of(imem_addr);
  assign imem_fault = imem_ack && fault_en && (imem_addr == fault_addr);

  // Wait-state counter for the current request.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_addr(input logic [29:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_de(input logic [29:0] pc, input logic exc);
    slot_t s;
    s.pc   = pc;
    s.exc  = exc;
    s.insn = exc ? 32'h0 : insn_of(pc);
    exp_de_q.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every memory handshake and every delivered instruction.
  initial begin
    slot_t s;
    logic [29:0] a;
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_imem_handshake", {2'b00, imem_addr}, 32'hFFFF_FFFF);
        end else begin
          a = exp_addr_q.pop_front();
          check("imem_addr_handshake", {2'b00, imem_addr}, {2'b00, a});
        end
      end
      if (de_valid && !de_stall) begin
        if (exp_de_q.size() == 0) begin
          check("unexpected_delivery_pc", {2'b00, de_pc}, 32'hFFFF_FFFF);
        end else begin
          s = exp_de_q.pop_front();
          check("de_pc", {2'b00, de_pc}, {2'b00, s.pc});
          check("de_insn", de_insn, s.insn);
          check("de_exc", {31'd0, de_exc}, {31'd0, s.exc});
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset_n  = 1'b0;
    de_stall = 1'b0;
    de_setpc = 1'b0;
    de_newpc = 30'h0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_de_valid", {31'd0, de_valid}, 32'd0);
    check("rst_de_exc", {31'd0, de_exc}, 32'd0);
    check("rst_de_insn", de_insn, 32'd0);
    check("rst_de_pc", {2'b00, de_pc}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);

    // Streaming, stall with skid, redirect coinciding with ack at 9.
    for (int i = 0; i <= 9; i++) push_addr(i[29:0]);
    for (int i = 0; i <= 8; i++) push_de(i[29:0], 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;                                   // C0
    #2;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", {2'b00, imem_addr}, 32'd0);
    for (int c = 1; c <= 5; c++) cyc();               // C1..C5
    cyc(); de_stall = 1'b1;                           // C6
    cyc(); #2;                                        // C7
    check("stall_req_low", {31'd0, imem_req}, 32'd0);
    check("stall_hold_valid", {31'd0, de_valid}, 32'd1);
    check("stall_hold_pc", {2'b00, de_pc}, 32'd5);
    cyc(); #2;                                        // C8
    check("stall_hold_pc2", {2'b00, de_pc}, 32'd5);
    cyc(); de_stall = 1'b0; #2;                       // C9
    check("release_req_low", {31'd0, imem_req}, 32'd0);
    cyc(); #2;                                        // C10
    check("skid_out_pc", {2'b00, de_pc}, 32'd6);
    check("after_skid_req", {31'd0, imem_req}, 32'd1);
    check("after_skid_addr", {2'b00, imem_addr}, 32'd7);
    cyc();                                            // C11
    cyc(); de_setpc = 1'b1; de_newpc = 30'd4;         // C12: ack of 9 discarded

    // Redirect while the request for 4 is pending.
    push_addr(30'd4);
    push_addr(30'h40); push_addr(30'h41); push_addr(30'h42);
    push_de(30'h40, 1'b0); push_de(30'h41, 1'b0);
    cyc(); de_setpc = 1'b0; mem_delay = 3; #2;        // C13
    check("redir_valid_low", {31'd0, de_valid}, 32'd0);
    check("redir_addr4", {2'b00, imem_addr}, 32'd4);
    cyc(); de_setpc = 1'b1; de_newpc = 30'h40;        // C14
    cyc(); de_setpc = 1'b0; #2;                       // C15
    check("kill_addr_held", {2'b00, imem_addr}, 32'd4);
    check("kill_req_held", {31'd0, imem_req}, 32'd1);
    check("kill_valid_low", {31'd0, de_valid}, 32'd0);
    cyc();                                            // C16: ack of 4 discarded
    cyc(); #2;                                        // C17
    check("kill_next_addr", {2'b00, imem_addr}, 32'h40);
    check("kill_next_valid", {31'd0, de_valid}, 32'd0);
    cyc(); cyc();                                     // C18, C19
    cyc(); #2;                                        // C20
    check("wait_valid_low", {31'd0, de_valid}, 32'd0);
    cyc(); mem_delay = 0; #2;                         // C21
    check("redir_data_valid", {31'd0, de_valid}, 32'd1);
    check("redir_data_pc", {2'b00, de_pc}, 32'h40);

    // Fault at address 2, then resume at 0x100.
    push_addr(30'd2);
    push_de(30'd2, 1'b1);
    push_addr(30'h100); push_addr(30'h101);
    push_de(30'h100, 1'b0); push_de(30'h101, 1'b0);
    cyc(); de_setpc = 1'b1; de_newpc = 30'd2;         // C22
    cyc(); de_setpc = 1'b0; fault_en = 1'b1;          // C23
    cyc(); #2;                                        // C24
    check("fault_valid", {31'd0, de_valid}, 32'd1);
    check("fault_exc", {31'd0, de_exc}, 32'd1);
    check("fault_insn", de_insn, 32'd0);
    check("fault_pc", {2'b00, de_pc}, 32'd2);
    check("halt_req_low", {31'd0, imem_req}, 32'd0);
    cyc();                                            // C25
    cyc(); #2;                                        // C26
    check("halt_req_still_low", {31'd0, imem_req}, 32'd0);
    cyc(); de_setpc = 1'b1; de_newpc = 30'h100; fault_en = 1'b0;  // C27
    cyc(); de_setpc = 1'b0; #2;                       // C28
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", {2'b00, imem_addr}, 32'h100);
    cyc();                                            // C29
    cyc(); mem_delay = 5;                             // C30: 0x102 left pending

    // Asynchronous reset with a request outstanding.
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_de_valid", {31'd0, de_valid}, 32'd0);
    check("async_de_pc", {2'b00, de_pc}, 32'd0);
    check("async_de_insn", de_insn, 32'd0);
    check("async_imem_req", {31'd0, imem_req}, 32'd0);
    check("async_imem_addr", {2'b00, imem_addr}, 32'd0);
    push_addr(30'd0); push_addr(30'd1); push_addr(30'd2);
    push_de(30'd0, 1'b0); push_de(30'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mem_delay = 0;
    reset_n   = 1'b1;                                 // R0
    #2;
    check("rerst_req", {31'd0, imem_req}, 32'd1);
    check("rerst_addr", {2'b00, imem_addr}, 32'd0);
    cyc(); cyc();                                     // R1, R2
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check("de_queue_drained", exp_de_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
